// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and mem_state codes for the
// LC-3 pipeline controller.
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] MS_RD   = 2'd0;
    localparam logic [1:0] MS_IND  = 2'd1;
    localparam logic [1:0] MS_WR   = 2'd2;
    localparam logic [1:0] MS_IDLE = 2'd3;

    typedef enum logic [2:0] {
        S_RUN, S_MEM_RD, S_MEM_IND, S_MEM_WR, S_BR_WAIT
    } state_e;

    // Opcodes whose execute result is written back to a register
    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
    endfunction

endpackage

// File: rtl/lc3_hazard_det.sv
// Combinational RAW detection between the decode-stage instruction and the
// register written by the instruction currently in execute.
module lc3_hazard_det
    import lc3_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] ir_exec,
    output logic        haz_src1,
    output logic        haz_src2
);

    logic [2:0] dr;
    logic       src2_is_reg;
    logic       unused_bits;

    assign dr          = ir_exec[11:9];
    assign src2_is_reg = ((ir[15:12] == OP_ADD) || (ir[15:12] == OP_AND)) && !ir[5];
    assign unused_bits = ^{ir[11:9], ir[4:3], ir_exec[8:0]};

    always_comb begin
        haz_src1 = is_alu(ir_exec[15:12]) && (ir[8:6] == dr);
        haz_src2 = src2_is_reg && (ir[2:0] == dr);
    end

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC-3 five-stage pipeline controller: fill, memory stalls, branch shadow.
// Define LC3_CTRL_BYPASS_EN to forward execute results instead of bubbling.
module lc3_pipe_ctrl
    import lc3_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [15:0] IMem_dout,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic [1:0]  mem_state
);

    state_e     state_q, state_d;
    logic [1:0] fill_q, fill_d, br_cnt_q, br_cnt_d;
    logic       mem_done_q, mem_done_d;
    logic       haz1, haz2, stall, exec_vld, mem_op;
    logic       upd, fet, dec, exe, wb, brt, byp1, byp2;
    logic [1:0] ms;
    logic [3:0] op_ex, op_if;
    logic       unused_bits;

    assign op_ex       = IR_Exec[15:12];
    assign op_if       = IMem_dout[15:12];
    assign exec_vld    = fill_q[1];
    assign mem_op      = (op_ex == OP_LD) || (op_ex == OP_LDR) || (op_ex == OP_LDI) ||
                         (op_ex == OP_ST) || (op_ex == OP_STR) || (op_ex == OP_STI);
    assign unused_bits = ^IMem_dout[11:0];

    lc3_hazard_det u_haz (
        .ir       (IR),
        .ir_exec  (IR_Exec),
        .haz_src1 (haz1),
        .haz_src2 (haz2)
    );

`ifdef LC3_CTRL_BYPASS_EN
    assign stall = 1'b0;
    assign byp1  = haz1 && exec_vld;
    assign byp2  = haz2 && exec_vld;
`else
    // bubble_q lets the dependent instruction through after one inserted bubble
    logic bubble_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bubble_q <= 1'b0;
        else      bubble_q <= (state_q == S_RUN) && complete_instr && stall;
    end
    assign stall = (haz1 || haz2) && exec_vld && !bubble_q;
    assign byp1  = 1'b0;
    assign byp2  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        br_cnt_d   = br_cnt_q;
        mem_done_d = mem_done_q;
        {upd, fet, dec, exe, wb, brt} = '0;
        ms = MS_IDLE;
        case (state_q)
            S_RUN: if (complete_instr) begin
                // Launch cycle freezes every stage so IR_Exec and the pending fetch are kept
                if (exec_vld && !mem_done_q && mem_op) begin
                    if ((op_ex == OP_LD) || (op_ex == OP_LDR))       state_d = S_MEM_RD;
                    else if ((op_ex == OP_LDI) || (op_ex == OP_STI)) state_d = S_MEM_IND;
                    else                                             state_d = S_MEM_WR;
                end else begin
                    upd        = !stall;
                    fet        = !stall;
                    dec        = (fill_q != 2'd0) && !stall;
                    exe        = exec_vld;
                    wb         = (fill_q == 2'd3) && is_alu(op_ex);
                    mem_done_d = 1'b0;
                    if (fill_q != 2'd3) fill_d = fill_q + 2'd1;
                    if (!stall && ((op_if == OP_BR) || (op_if == OP_JMP))) begin
                        state_d  = S_BR_WAIT;
                        br_cnt_d = 2'd2;
                    end
                end
            end
            S_MEM_RD: begin
                ms = MS_RD;
                if (complete_data) begin
                    wb         = 1'b1;
                    state_d    = S_RUN;
                    mem_done_d = 1'b1;
                end
            end
            S_MEM_IND: begin
                ms = MS_IND;
                if (complete_data) state_d = (op_ex == OP_LDI) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_WR: begin
                ms = MS_WR;
                if (complete_data) begin
                    state_d    = S_RUN;
                    mem_done_d = 1'b1;
                end
            end
            S_BR_WAIT: begin
                dec = 1'b1;
                exe = 1'b1;
                wb  = (fill_q == 2'd3) && is_alu(op_ex);
                // The branch reaches execute two cycles after it was fetched
                brt = (br_cnt_q == 2'd1) &&
                      (((op_ex == OP_BR) && |(NZP & psr)) || (op_ex == OP_JMP));
                if (fill_q != 2'd3) fill_d = fill_q + 2'd1;
                if (br_cnt_q == 2'd0) state_d  = S_RUN;
                else                  br_cnt_d = br_cnt_q - 2'd1;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            fill_q     <= 2'd0;
            br_cnt_q   <= 2'd0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            br_cnt_q   <= br_cnt_d;
            mem_done_q <= mem_done_d;
        end
    end

    // Outputs are forced to their idle values the moment reset is asserted
    assign enable_updatePC  = rst & upd;
    assign enable_fetch     = rst & fet;
    assign enable_decode    = rst & dec;
    assign enable_execute   = rst & exe;
    assign enable_writeback = rst & wb;
    assign br_taken         = rst & brt;
    assign bypass_alu_1     = rst & byp1;
    assign bypass_alu_2     = rst & byp2;
    assign mem_state        = rst ? ms : MS_IDLE;

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl; observed outputs packed as
// {updatePC,fetch,decode,execute,writeback | br_taken,byp1,byp2 | mem_state}.
module tb_lc3_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, complete_instr, complete_data;
    logic [15:0] IR, IR_Exec, IMem_dout;
    logic [2:0]  NZP, psr;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken, bypass_alu_1, bypass_alu_2;
    logic [1:0]  mem_state;
    logic [9:0]  obs;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign NZP = IR_Exec[11:9];
    assign obs = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
                  br_taken, bypass_alu_1, bypass_alu_2, mem_state};

    lc3_pipe_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .IMem_dout        (IMem_dout),
        .NZP              (NZP),
        .psr              (psr),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .mem_state        (mem_state)
    );

    task automatic test_reset();
        rst = 1'b0; complete_instr = 1'b1; complete_data = 1'b0;
        IR = 16'h0000; IR_Exec = 16'h1261; IMem_dout = 16'h1000; psr = 3'b000;
        for (int i = 0; i < 2; i++) begin
            repeat (2) @(negedge clk);
            if (i == 1) begin IR_Exec = 16'h2202; complete_data = 1'b1; IMem_dout = 16'h0402; end
            #1;
            n_vec++;
            if (obs !== 10'b00000_000_11) begin
                n_err++; $display("FAIL reset %0d: got %b want %b", i, obs, 10'b00000_000_11);
            end
        end
        IR_Exec = 16'h1261; complete_data = 1'b0; IMem_dout = 16'h1000;
    endtask

    task automatic test_fill();
        logic [9:0] want [4];
        want = '{10'b11000_000_11, 10'b11100_000_11, 10'b11110_000_11, 10'b11111_000_11};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b1;
            #1;
            n_vec++;
            if (obs !== want[i]) begin
                n_err++; $display("FAIL fill cycle %0d: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_no_instr();
        logic [9:0] want [3];
        want = '{10'b00000_000_11, 10'b00000_000_11, 10'b11111_000_11};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            complete_instr = (i == 2);
            #1;
            n_vec++;
            if (obs !== want[i]) begin
                n_err++; $display("FAIL no_instr %0d: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_ld();
        logic [9:0] want [7];
        want = '{10'b00000_000_11, 10'b00000_000_00, 10'b00000_000_00, 10'b00000_000_00,
                 10'b00001_000_00, 10'b11110_000_11, 10'b11111_000_11};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            case (i)
                0: IR_Exec = 16'h2202;
                4: complete_data = 1'b1;
                5: complete_data = 1'b0;
                6: IR_Exec = 16'h1261;
                default: ;
            endcase
            #1;
            n_vec++;
            if (obs !== want[i]) begin
                n_err++; $display("FAIL ld step %0d: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_sti();
        logic [9:0] want [7];
        want = '{10'b00000_000_11, 10'b00000_000_01, 10'b00000_000_01, 10'b00000_000_10,
                 10'b00000_000_10, 10'b11110_000_11, 10'b11111_000_11};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            case (i)
                0: IR_Exec = 16'hB201;
                6: IR_Exec = 16'h1261;
                default: ;
            endcase
            complete_data = (i == 2) || (i == 4);
            #1;
            n_vec++;
            if (obs !== want[i]) begin
                n_err++; $display("FAIL sti step %0d: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_branch(input logic [2:0] flags, input logic taken);
        logic [9:0] want [6];
        want = '{10'b11111_000_11, 10'b00111_000_11, {5'b00110, taken, 4'b0011},
                 10'b00110_000_11, 10'b11110_000_11, 10'b11111_000_11};
        psr = flags;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            case (i)
                0: begin IMem_dout = 16'h0402; IR_Exec = 16'h1261; IR = 16'h0000; end
                1: begin IMem_dout = 16'h1000; IR = 16'h0402; end
                2: begin IR_Exec = 16'h0402; IR = 16'h0000; end
                5: IR_Exec = 16'h1261;
                default: ;
            endcase
            #1;
            n_vec++;
            if (obs !== want[i]) begin
                n_err++; $display("FAIL branch psr=%b step %0d: got %b want %b", flags, i, obs, want[i]);
            end
        end
    endtask

    task automatic test_hazard();
        logic [9:0] want [3];
`ifdef LC3_CTRL_BYPASS_EN
        want = '{10'b11111_011_11, 10'b11111_011_11, 10'b11111_000_11};
`else
        want = '{10'b00011_000_11, 10'b11111_000_11, 10'b11111_000_11};
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            IR = (i == 2) ? 16'h0000 : 16'h1441;
            IR_Exec = 16'h1261;
            #1;
            n_vec++;
            if (obs !== want[i]) begin
                n_err++; $display("FAIL hazard step %0d: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_mem_br_priority();
        logic [9:0] want [7];
        want = '{10'b00000_000_11, 10'b00001_000_00, 10'b11110_000_11, 10'b00111_000_11,
                 10'b00111_000_11, 10'b00111_000_11, 10'b11111_000_11};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            case (i)
                0: begin IR_Exec = 16'h6000; IMem_dout = 16'h0402; end
                3: begin IR_Exec = 16'h1261; IMem_dout = 16'h1000; end
                default: ;
            endcase
            complete_data = (i == 1);
            #1;
            n_vec++;
            if (obs !== want[i]) begin
                n_err++; $display("FAIL mem_br step %0d: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [9:0] want [4];
        want = '{10'b00000_000_11, 10'b00000_000_00, 10'b00000_000_11, 10'b11000_000_11};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                #1 rst = 1'b0;
            end else begin
                @(negedge clk);
                case (i)
                    0: IR_Exec = 16'h2202;
                    3: begin rst = 1'b1; IR_Exec = 16'h1261; end
                    default: ;
                endcase
            end
            #1;
            n_vec++;
            if (obs !== want[i]) begin
                n_err++; $display("FAIL reset_mid_mem step %0d: got %b want %b", i, obs, want[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_no_instr();
        test_ld();
        test_sti();
        test_branch(3'b010, 1'b1);
        test_branch(3'b100, 1'b0);
        test_hazard();
        test_mem_br_priority();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
